// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: PC register, imem request/response handshake, decode handoff
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_VALID = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        consume;

    assign consume = (state_q == S_VALID) && inst_ready_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                state_d = (RESET_PC[1:0] != 2'b00) ? S_FAULT : S_REQ;
            end
            S_REQ: begin
                // rvalid only counts once the request has been accepted
                if (imem_ready_i) begin
                    if (imem_rvalid_i) begin
                        instr_d = imem_rdata_i;
                        state_d = S_VALID;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (consume) begin
                    // misaligned target is still loaded so it can be inspected
                    pc_d    = next_i;
                    count_d = count_q + 32'd1;
                    state_d = (next_i[1:0] == 2'b00) ? S_REQ : S_FAULT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign instruction_o = instr_q;
    assign fetch_count_o = count_q;
    assign imem_req_o    = (state_q == S_REQ);
    assign inst_valid_o  = (state_q == S_VALID);
    assign fault_o       = (state_q == S_FAULT);

endmodule
